// File: rtl/mem_burst_responder_pkg.sv
// rtl/mem_burst_responder_pkg.sv - shared types and helpers for the burst responder
//
// Purpose: state encoding of the responder FSM and a constant log2 helper
//          used to size the burst issue counter.
// Ports:   none (package).
package mem_burst_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions; burst_log2(1) = 0.
  function automatic int burst_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_rdpipe.sv
// rtl/mem_resp_rdpipe.sv - read-valid delay line matching the SRAM read latency
//
// Purpose: carries the SRAM read strobe through an RDLAT-deep shift register so
//          the flag lines up with sram_rdata, then registers it once more to
//          become mem_valid (aligned with the registered mem_out).
// Ports:   clk, reset_n (async, active-low)
//          re       - SRAM read strobe as issued this cycle
//          load_en  - sram_rdata carries a burst word now; load mem_out
//          valid    - mem_out holds a burst word this cycle
//          empty    - no read in flight inside the delay line
module mem_resp_rdpipe
  import mem_burst_responder_pkg::*;
#(
  parameter int RDLAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic re,
  output logic load_en,
  output logic valid,
  output logic empty
);

  logic [RDLAT-1:0] pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe  <= '0;
      valid <= 1'b0;
    end else begin
      pipe[0] <= re;
      for (int i = 1; i < RDLAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      valid <= pipe[RDLAT-1];
    end
  end

  assign load_en = pipe[RDLAT-1];
  assign empty   = ~|pipe;

endmodule

// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - cache burst protocol responder onto a synchronous SRAM
//
// Purpose: accepts single-word writes and aligned burst reads from a cache
//          controller, drives a single-port SRAM, and streams read bursts back
//          as consecutive mem_valid words.
// Ports:   clk, reset_n (async, active-low)
//          mem_addr/mem_in/mem_rdreq/mem_wrreq - cache request side
//          mem_out/mem_valid                   - returned burst data
//          mem_burstlen                        - advertised burst length
//          mem_busy/mem_err                    - burst in progress / sticky error
//          sram_addr/sram_wdata/sram_we/sram_re/sram_rdata - SRAM side
//          stat_rdbursts/stat_wrwords          - saturating counters, present
//                                                only when the macro
//                                                MEM_BURST_RESPONDER_STATS_EN
//                                                is defined
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int MEMADDRBITS = 12,
  parameter int BURSTLEN    = 8,
  parameter int RDLAT       = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDRBITS-1:0]    mem_addr,
  input  logic [DATABITS-1:0]    mem_in,
  input  logic                   mem_rdreq,
  input  logic                   mem_wrreq,
  output logic [DATABITS-1:0]    mem_out,
  output logic                   mem_valid,
  output logic [15:0]            mem_burstlen,
  output logic                   mem_busy,
  output logic                   mem_err,
  output logic [MEMADDRBITS-1:0] sram_addr,
  output logic [DATABITS-1:0]    sram_wdata,
  output logic                   sram_we,
  output logic                   sram_re,
  input  logic [DATABITS-1:0]    sram_rdata
`ifdef MEM_BURST_RESPONDER_STATS_EN
  ,
  output logic [31:0]            stat_rdbursts,
  output logic [31:0]            stat_wrwords
`endif
);

  // Counter needs one extra bit so it can hold BURSTLEN itself.
  localparam int                     CNTW     = burst_log2(BURSTLEN) + 1;
  localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(BURSTLEN);
  localparam logic [MEMADDRBITS-1:0] OFFMASK  = MEMADDRBITS'(BURSTLEN - 1);

  state_t                 state;
  logic [MEMADDRBITS-1:0] base;
  logic [CNTW-1:0]        cnt;
  logic [MEMADDRBITS-1:0] req_waddr;
  logic                   req_any;
  logic                   load_en;
  logic                   pipe_empty;
  logic                   unused_addr;

  assign req_waddr    = mem_addr[MEMADDRBITS+1:2];
  assign req_any      = mem_rdreq | mem_wrreq;
  assign mem_burstlen = 16'(BURSTLEN);
  // Byte offset and bits above the SRAM size are intentionally ignored.
  assign unused_addr  = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};

  // The first address of a burst goes out on the IDLE->RD_ISSUE transition,
  // so cnt counts addresses already issued and starts at 1 in RD_ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base       <= '0;
      cnt        <= '0;
      mem_busy   <= 1'b0;
      mem_err    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
    end else begin
      sram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_wrreq) begin
            sram_we    <= 1'b1;
            sram_addr  <= req_waddr;
            sram_wdata <= mem_in;
            // A simultaneous read is dropped in favour of the write.
            if (mem_rdreq) mem_err <= 1'b1;
          end else if (mem_rdreq) begin
            base      <= req_waddr & ~OFFMASK;
            sram_addr <= req_waddr & ~OFFMASK;
            sram_re   <= 1'b1;
            cnt       <= CNTW'(1);
            mem_busy  <= 1'b1;
            state     <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (req_any) mem_err <= 1'b1;
          if (cnt == CNT_LAST) begin
            sram_re <= 1'b0;
            state   <= RD_DRAIN;
          end else begin
            sram_re <= 1'b1;
            // OR into the aligned base keeps the burst inside its window.
            sram_addr <= base | (MEMADDRBITS'(cnt) & OFFMASK);
            cnt       <= cnt + 1'b1;
          end
        end
        RD_DRAIN: begin
          if (req_any) mem_err <= 1'b1;
          // With no strobe issuing and the delay line empty, the word in
          // mem_out this cycle is the last of the burst.
          if (pipe_empty) begin
            mem_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
          sram_re  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_out <= '0;
    end else if (load_en) begin
      mem_out <= sram_rdata;
    end
  end

  mem_resp_rdpipe #(
    .RDLAT (RDLAT)
  ) u_rdpipe (
    .clk     (clk),
    .reset_n (reset_n),
    .re      (sram_re),
    .load_en (load_en),
    .valid   (mem_valid),
    .empty   (pipe_empty)
  );

`ifdef MEM_BURST_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rdbursts <= '0;
      stat_wrwords  <= '0;
    end else if (state == IDLE) begin
      if (mem_wrreq) begin
        if (stat_wrwords != 32'hFFFF_FFFF) stat_wrwords <= stat_wrwords + 32'd1;
      end else if (mem_rdreq) begin
        if (stat_rdbursts != 32'hFFFF_FFFF) stat_rdbursts <= stat_rdbursts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the cache burst protocol: accepts `mem_rdreq`/`mem_wrreq` from a cache controller, turns them into accesses on a single-port synchronous SRAM, and returns read bursts as a stream of `mem_valid` words. It sits between the data/instruction cache's memory port and the on-chip backing RAM, and advertises the burst length the cache must use.

## Interface

- `ADDRBITS`, 32, width of the byte address on the cache side
- `DATABITS`, 32, data word width
- `MEMADDRBITS`, 12, SRAM word-address width
- `BURSTLEN`, 8, words per read burst; power of two, 1..2**MEMADDRBITS
- `RDLAT`, 1, SRAM read latency in cycles; 1 or 2
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `mem_addr`  in  ADDRBITS  byte address; read base or write target
- `mem_in`  in  DATABITS  write data
- `mem_rdreq`  in  1  one-cycle burst read request
- `mem_wrreq`  in  1  single-word write, one word per high cycle
- `mem_out`  out  DATABITS  read data
- `mem_valid`  out  1  `mem_out` holds a burst word this cycle
- `mem_burstlen`  out  16  constant BURSTLEN
- `mem_busy`  out  1  read burst in progress; requests ignored
- `mem_err`  out  1  sticky protocol-error flag
- `sram_addr`  out  MEMADDRBITS  SRAM word address
- `sram_wdata`  out  DATABITS  SRAM write data
- `sram_we`  out  1  SRAM write strobe
- `sram_re`  out  1  SRAM read strobe
- `sram_rdata`  in  DATABITS  SRAM read data, valid RDLAT cycles after `sram_re`

## Operation

- Word address = `mem_addr[MEMADDRBITS+1:2]`. Upper bits ignored, so addresses wrap modulo SRAM size. Byte offset bits [1:0] are ignored.
- State machine, with states IDLE, RD_ISSUE and RD_DRAIN:
  - IDLE, `mem_wrreq`: register address and data; `sram_we` pulses in the next cycle. No state change, and no limit on consecutive writes.
  - IDLE, `mem_rdreq` (and no `mem_wrreq`): latch the base address with the low log2(BURSTLEN) word bits forced to 0. Clear the issue counter and go to RD_ISSUE.
  - RD_ISSUE: each cycle, `sram_re`=1 and `sram_addr`=base+count. After issuing BURSTLEN addresses, go to RD_DRAIN.
  - RD_DRAIN: wait for the RDLAT-deep valid pipe to empty and the last word to be presented, then go to IDLE.
- Returned data: the SRAM data is registered into `mem_out`, and `mem_valid` is a delayed copy of `sram_re`. `mem_out` holds its last value when `mem_valid`=0.
- `mem_rdreq` and `mem_wrreq` both high in IDLE: the write executes, the read is dropped, and `mem_err` is set.
- Any request while `mem_busy`=1: ignored, and `mem_err` is set.
- `mem_err` clears only on reset.
- Base address + count wraps inside the aligned burst window; it never crosses into the next window.

## Timing

- Reset values:
  - `mem_out`=0, `mem_valid`=0, `mem_busy`=0, `mem_err`=0
  - `sram_addr`=0, `sram_wdata`=0, `sram_we`=0, `sram_re`=0
  - `mem_burstlen`=BURSTLEN (constant); state IDLE
- Read with `mem_rdreq` sampled in cycle T:
  - `mem_busy` is high from T+1 through the cycle of the last `mem_valid`.
  - `sram_re` is high in T+1..T+BURSTLEN.
  - `mem_valid` is high in T+RDLAT+2..T+RDLAT+BURSTLEN+1, on consecutive cycles with no gaps.
  - The next request is accepted in the cycle after the last `mem_valid`.
- Write with `mem_wrreq` sampled in T: `sram_we` is high in T+1 with that cycle's address and data. `mem_busy` stays 0.
- Ordering: a read requested in T+1 after a write in T issues its first `sram_re` in T+2, so it observes the written data.
- Reset asserted mid-burst: the burst is aborted immediately, all outputs go to their reset values, and no further `mem_valid` is produced.

## Configuration

- `MEM_BURST_RESPONDER_STATS_EN` defined:
  - Adds outputs `stat_rdbursts` and `stat_wrwords`, both 32 bit, reset 0.
  - `stat_rdbursts` counts accepted read bursts.
  - `stat_wrwords` counts executed writes.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure

- Package `mem_burst_responder_pkg`: state encodings (IDLE, RD_ISSUE, RD_DRAIN) and the `BURSTLEN` width helper (log2 constant).
- Sub-module `mem_resp_rdpipe`: RDLAT-deep shift register carrying the read-valid flag. It raises `mem_valid` and the `mem_out` load enable.
- Everything else is flat in the top module.

## Test plan

- Reset, then write words 0xA0+i to word addresses 0x10..0x17 on consecutive cycles → `sram_we` high 8 cycles starting one cycle later, with matching addresses and data.
- `mem_rdreq` with `mem_addr`=0x44 (word 0x11), BURSTLEN=8, RDLAT=1 → base word 0x10; `mem_valid` high 8 consecutive cycles starting T+3 with data 0xA0..0xA7; `mem_busy` high T+1..T+10.
- Same read with RDLAT=2 → first `mem_valid` at T+4, same data, no gaps.
- `mem_rdreq` pulsed again during a burst, plus a cycle with `mem_rdreq`=`mem_wrreq`=1 in IDLE → extra read ignored, write performed, `mem_err`=1 and stays 1.
- Write to word 0x20 in cycle T, then `mem_rdreq` to 0x80 in T+1 → first returned word equals the newly written data.
- Assert `reset_n` low at the 3rd `mem_valid` of a burst → all outputs 0 immediately; with `MEM_BURST_RESPONDER_STATS_EN` defined, stat counters read 0 after reset and 1 after one subsequent burst.
